// File: rtl/nn_mac_engine.sv
// nn_mac_engine: streams a stored pixel vector against each neuron's weight row
// and accumulates one saturating signed dot product per output neuron.
// Ports:
//   clk, n_rst              clock, asynchronous active-low reset
//   start_calc              start request, accepted in IDLE or DONE
//   output_address          result register select for result_output
//   pixel_raddr/rdata       pixel RAM port, data valid one cycle after address
//   weight_raddr/rdata      weight RAM port, row-major, same one-cycle latency
//   result_output           selected result, 0 for addresses beyond N_OUTPUTS
//   done_calc, busy         completion flag and run-in-progress flag
module nn_mac_engine #(
   parameter int N_INPUTS  = 784,
   parameter int N_OUTPUTS = 10,
   parameter int DATA_W    = 16
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic              start_calc,
   input  logic [3:0]        output_address,
   output logic [9:0]        pixel_raddr,
   input  logic [DATA_W-1:0] pixel_rdata,
   output logic [12:0]       weight_raddr,
   input  logic [DATA_W-1:0] weight_rdata,
   output logic [31:0]       result_output,
   output logic              done_calc,
   output logic              busy
);
   typedef enum logic [2:0] {IDLE, MAC, DRAIN1, DRAIN2, STORE, DONE} state_t;
   localparam logic [9:0] LAST_I = 10'(N_INPUTS - 1);
   localparam logic [3:0] LAST_N = 4'(N_OUTPUTS - 1);
   state_t state_q, state_d;
   logic [9:0] i_q, i_d;
   logic [3:0] n_q, n_d;
   logic [12:0] wa_q, wa_d;
   logic v1_q, v1_d, v2_q, v2_d;
   logic [31:0] prod_q, prod_d, acc_q, acc_d;
   logic [31:0] res_q [N_OUTPUTS];
   logic [31:0] res_d [N_OUTPUTS];
   logic signed [2*DATA_W-1:0] mul;
   logic [32:0] sum;
   always_ff @(posedge clk or negedge n_rst)
      if (!n_rst) begin
         state_q <= IDLE;
         i_q     <= '0;
         n_q     <= '0;
         wa_q    <= '0;
         v1_q    <= 1'b0;
         v2_q    <= 1'b0;
         prod_q  <= '0;
         acc_q   <= '0;
         res_q   <= '{default: '0};
      end else begin
         state_q <= state_d;
         i_q     <= i_d;
         n_q     <= n_d;
         wa_q    <= wa_d;
         v1_q    <= v1_d;
         v2_q    <= v2_d;
         prod_q  <= prod_d;
         acc_q   <= acc_d;
         res_q   <= res_d;
      end
   always_comb begin
      state_d = state_q;
      i_d     = i_q;
      n_d     = n_q;
      wa_d    = wa_q;
      res_d   = res_q;
      // v1 marks RAM data returning this cycle, v2 marks a valid product register
      v1_d    = state_q == MAC;
      v2_d    = v1_q;
      mul     = $signed(pixel_rdata) * $signed(weight_rdata);
      prod_d  = 32'(mul);
      // 33-bit sum: differing top two bits mean the 32-bit result overflowed
      sum     = {acc_q[31], acc_q} + {prod_q[31], prod_q};
      acc_d   = !v2_q ? acc_q : sum[32] == sum[31] ? sum[31:0] : sum[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
      case (state_q)
         IDLE, DONE: if (start_calc) begin
            state_d = MAC;
            i_d     = '0;
            n_d     = '0;
            wa_d    = '0;
            v1_d    = 1'b0;
            v2_d    = 1'b0;
            acc_d   = '0;
         end
         MAC: begin
            i_d     = i_q + 10'd1;
            wa_d    = wa_q + 13'd1;
            state_d = i_q == LAST_I ? DRAIN1 : MAC;
         end
         DRAIN1: state_d = DRAIN2;
         DRAIN2: state_d = STORE;
         STORE: begin
            for (int k = 0; k < N_OUTPUTS; k++)
               if (n_q == 4'(k)) res_d[k] = acc_q;
            acc_d   = '0;
            i_d     = '0;
            n_d     = n_q == LAST_N ? n_q : n_q + 4'd1;
            state_d = n_q == LAST_N ? DONE : MAC;
         end
         default: state_d = IDLE;
      endcase
   end
   always_comb begin
      result_output = '0;
      for (int k = 0; k < N_OUTPUTS; k++)
         if (output_address == 4'(k)) result_output = res_q[k];
   end
   assign pixel_raddr  = i_q;
   assign weight_raddr = wa_q;
   assign done_calc    = state_q == DONE;
   assign busy         = state_q inside {MAC, DRAIN1, DRAIN2, STORE};
endmodule

// File: tb/tb_nn_mac_engine.sv
// tb_nn_mac_engine: runs a 4x2 and a default-size engine against a cycle-level
// reference built from the run timeline and plain saturating dot products.
module tb_nn_mac_engine;
   logic clk = 1'b0, n_rst = 1'b0, start_s = 1'b0, start_b = 1'b0;
   logic [3:0] addr = '0;
   logic [9:0] pa_s, pa_b;
   logic [12:0] wa_s, wa_b;
   logic [15:0] pd_s, wd_s, pd_b, wd_b;
   logic [31:0] res_s, res_b;
   logic done_s, done_b, busy_s, busy_b;
   logic [15:0] pix [1024];
   logic [15:0] w [8192];
   int ec = 0, n_chk = 0, n_fail = 0, cyc;
   bit st_s = 0, st_b = 0;
   int e_s = 0, e_b = 0;
   logic [31:0] old_s [16], fin_s [16], old_b [16], fin_b [16];

   always #5 clk = ~clk;

   nn_mac_engine #(.N_INPUTS(4), .N_OUTPUTS(2), .DATA_W(16)) u_small (
      .clk(clk), .n_rst(n_rst), .start_calc(start_s), .output_address(addr),
      .pixel_raddr(pa_s), .pixel_rdata(pd_s), .weight_raddr(wa_s), .weight_rdata(wd_s),
      .result_output(res_s), .done_calc(done_s), .busy(busy_s));

   nn_mac_engine u_big (
      .clk(clk), .n_rst(n_rst), .start_calc(start_b), .output_address(addr),
      .pixel_raddr(pa_b), .pixel_rdata(pd_b), .weight_raddr(wa_b), .weight_rdata(wd_b),
      .result_output(res_b), .done_calc(done_b), .busy(busy_b));

   // both engines share one RAM image through separate synchronous read ports
   always @(posedge clk) begin
      pd_s <= pix[pa_s];
      wd_s <= w[wa_s];
      pd_b <= pix[pa_b];
      wd_b <= w[wa_b];
   end

   task automatic chk(input string nm, input longint act, input longint exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at edge %0d", nm, act, exp, ec);
      end
   endtask

   function automatic logic [31:0] dot(input int n, input int ni);
      longint a = 0, mx = 64'sd2147483647, mn = -64'sd2147483648;
      for (int i = 0; i < ni; i++) begin
         a += longint'($signed(pix[i])) * longint'($signed(w[n * ni + i]));
         a = a > mx ? mx : a < mn ? mn : a;
      end
      return a[31:0];
   endfunction

   // reference timeline: start accepted at edge e, cycle c = ec - e + 1,
   // each neuron takes ni+3 cycles, result j visible after cycle (j+1)*(ni+3)
   always @(posedge clk) begin
      if (!n_rst) begin
         st_s = 0;
         st_b = 0;
         old_s = '{default: '0};
         old_b = '{default: '0};
      end else begin
         if (start_s && (!st_s || ec - e_s + 1 > 2 * 7)) begin
            if (st_s) old_s = fin_s;
            for (int j = 0; j < 2; j++) fin_s[j] = dot(j, 4);
            st_s = 1;
            e_s = ec + 1;
         end
         if (start_b && (!st_b || ec - e_b + 1 > 10 * 787)) begin
            if (st_b) old_b = fin_b;
            for (int j = 0; j < 10; j++) fin_b[j] = dot(j, 784);
            st_b = 1;
            e_b = ec + 1;
         end
      end
      ec++;
   end

   task automatic check_inst(input string tg, input int ni, input int no, input bit st, input int e,
                             input logic [31:0] old [16], input logic [31:0] fin [16],
                             input logic bz, input logic dn, input logic [9:0] pa,
                             input logic [12:0] wa, input logic [31:0] rs);
      int c, p, t;
      logic [31:0] er;
      p = ni + 3;
      t = no * p;
      c = st ? ec - e + 1 : 0;
      if (!n_rst) begin
         chk({tg, "_rst_busy"}, bz, 0);
         chk({tg, "_rst_done"}, dn, 0);
         chk({tg, "_rst_paddr"}, pa, 0);
         chk({tg, "_rst_waddr"}, wa, 0);
         chk({tg, "_rst_result"}, rs, 0);
         return;
      end
      chk({tg, "_busy"}, bz, st && c <= t);
      chk({tg, "_done"}, dn, st && c > t);
      if (!st) begin
         chk({tg, "_idle_paddr"}, pa, 0);
         chk({tg, "_idle_waddr"}, wa, 0);
      end else if (c <= t && (c - 1) % p < ni) begin
         chk({tg, "_paddr"}, pa, (c - 1) % p);
         chk({tg, "_waddr"}, wa, (c - 1) / p * ni + (c - 1) % p);
      end
      er = 32'd0;
      if (int'(addr) < no) er = (st && c > (int'(addr) + 1) * p) ? fin[addr] : old[addr];
      chk({tg, "_result"}, rs, er);
   endtask

   always @(negedge clk) begin
      check_inst("s", 4, 2, st_s, e_s, old_s, fin_s, busy_s, done_s, pa_s, wa_s, res_s);
      check_inst("b", 784, 10, st_b, e_b, old_b, fin_b, busy_b, done_b, pa_b, wa_b, res_b);
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // start one engine, optionally re-pulse start at cycle gl, return the done cycle
   task automatic run(input bit big, input int gl, input int lim, output int cy);
      if (big) start_b = 1'b1; else start_s = 1'b1;
      tick(1);
      start_b = 1'b0;
      start_s = 1'b0;
      chk(big ? "done_drop_b" : "done_drop_s", big ? done_b : done_s, 0);
      cy = -1;
      for (int k = 1; k <= lim; k++) begin
         if ((big ? done_b : done_s) === 1'b1) begin
            cy = k;
            break;
         end
         addr = 4'($urandom_range(0, 15));
         if (big) start_b = k == gl; else start_s = k == gl;
         tick(1);
      end
      start_b = 1'b0;
      start_s = 1'b0;
   endtask

   task automatic rd(input string nm, input bit big, input int a, input logic [31:0] exp);
      tick(1);
      addr = 4'(a);
      #1;
      chk(nm, big ? res_b : res_s, exp);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      for (int i = 0; i < 1024; i++) pix[i] = '0;
      for (int i = 0; i < 8192; i++) w[i] = '0;
      old_s = '{default: '0};
      old_b = '{default: '0};
      fin_s = '{default: '0};
      fin_b = '{default: '0};
      tick(3);
      chk("rst_done", done_s, 0);
      chk("rst_busy", busy_b, 0);
      chk("rst_waddr", wa_b, 0);
      n_rst = 1'b1;
      for (int a = 0; a < 16; a++) begin
         rd("rst_res_s", 0, a, 32'd0);
         chk("rst_res_b", res_b, 0);
      end

      // directed 4x2 dot products
      {pix[0], pix[1], pix[2], pix[3]} = {16'd1, 16'd2, 16'd3, 16'd4};
      {w[0], w[1], w[2], w[3]} = {16'd1, 16'd1, 16'd1, 16'd1};
      {w[4], w[5], w[6], w[7]} = {-16'sd1, 16'sd2, -16'sd3, 16'sd4};
      run(0, 0, 100, cyc);
      chk("small_done_cycle", cyc, 15);
      rd("small_res0", 0, 0, 32'd10);
      rd("small_res1", 0, 1, 32'd10);

      // restart from DONE with an ignored start pulse mid-run
      run(0, 5, 100, cyc);
      chk("ignored_start_done_cycle", cyc, 15);
      rd("ignored_res0", 0, 0, 32'd10);
      rd("ignored_res1", 0, 1, 32'd10);

      // saturation both ways
      for (int i = 0; i < 4; i++) pix[i] = 16'h7FFF;
      for (int i = 0; i < 8; i++) w[i] = 16'h7FFF;
      run(0, 0, 100, cyc);
      chk("sat_pos_cycle", cyc, 15);
      rd("sat_pos_res0", 0, 0, 32'h7FFF_FFFF);
      rd("sat_pos_res1", 0, 1, 32'h7FFF_FFFF);
      for (int i = 0; i < 8; i++) w[i] = 16'h8001;
      run(0, 0, 100, cyc);
      rd("sat_neg_res0", 0, 0, 32'h8000_0000);

      // asynchronous reset in cycle 6 of a run
      addr = 4'd0;
      start_s = 1'b1;
      tick(1);
      start_s = 1'b0;
      tick(5);
      n_rst = 1'b0;
      #1;
      chk("midrst_busy", busy_s, 0);
      chk("midrst_waddr", wa_s, 0);
      chk("midrst_result", res_s, 0);
      tick(2);
      n_rst = 1'b1;
      for (int i = 0; i < 4; i++) pix[i] = 16'($urandom);
      for (int i = 0; i < 8; i++) w[i] = 16'($urandom);
      run(0, 0, 100, cyc);
      chk("post_rst_cycle", cyc, 15);
      rd("post_rst_res0", 0, 0, dot(0, 4));
      rd("post_rst_res1", 0, 1, dot(1, 4));

      // default sizes: full-range random data, then narrow data with a start glitch
      for (int i = 0; i < 784; i++) pix[i] = 16'($urandom);
      for (int i = 0; i < 7840; i++) w[i] = 16'($urandom);
      run(1, 0, 9000, cyc);
      chk("big_done_cycle", cyc, 7871);
      rd("big_addr12", 1, 12, 32'd0);
      for (int i = 0; i < 784; i++) pix[i] = 16'($signed(10'($urandom)));
      for (int i = 0; i < 7840; i++) w[i] = 16'($signed(10'($urandom)));
      run(1, 100, 9000, cyc);
      chk("big2_done_cycle", cyc, 7871);
      for (int a = 0; a < 16; a++) tick(1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
